nibble_serial_subtractor_ctrl: RTL

//  Sequencer for one 4-bit ripple-borrow subtractor slice, reused over NIBBLES cycles
//  to compute a wide difference d = a - b - bin (W = 4*NIBBLES bits).

---
 rtl/nibble_serial_subtractor_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/nibble_serial_subtractor_ctrl.sv
// Serial W-bit subtractor: one 4-bit ripple-borrow slice reused over NIBBLES cycles, LS nibble first.
// Latency NIBBLES+1 cycles from accepted start to the done pulse; start is ignored while busy.
module nibble_serial_subtractor_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 bin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] d,
    output logic                 bout,
    output logic                 zero
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   a_q, b_q;
    logic           brw;
    logic [IW-1:0]  idx;
    logic           last_nib;
    logic [3:0]     a_nib, b_nib, diff;
    logic [4:0]     bc;
    logic [W-1:0]   d_nxt;

    assign last_nib = (idx == IW'(NIBBLES - 1));
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // One ripple-borrow slice on the nibble selected by idx; d_nxt is d with that nibble replaced.
    always_comb begin
        a_nib = a_q[{idx, 2'b00} +: 4];
        b_nib = b_q[{idx, 2'b00} +: 4];
        diff  = '0;
        bc    = '0;
        bc[0] = brw;
        for (int i = 0; i < 4; i++) begin
            diff[i]  = a_nib[i] ^ b_nib[i] ^ bc[i];
            bc[i+1]  = (~a_nib[i] & b_nib[i]) | ((~a_nib[i] | b_nib[i]) & bc[i]);
        end
        d_nxt = d;
        d_nxt[{idx, 2'b00} +: 4] = diff;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_nib) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            brw  <= 1'b0;
            idx  <= '0;
            d    <= '0;
            bout <= 1'b0;
            zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q  <= a;
                        b_q  <= b;
                        brw  <= bin;
                        idx  <= '0;
                        d    <= '0;
                        zero <= 1'b0;
                    end
                end
                RUN: begin
                    d   <= d_nxt;
                    brw <= bc[4];
                    if (last_nib) begin
                        idx  <= '0;
                        bout <= bc[4];
                        zero <= (d_nxt == '0);
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
